// File: rtl/vx_commit_accum_pkg.sv
// Shared sizing helpers for commit accounting.
// Keeps the CSR unit and commit paths agreeing on widths.
package vx_commit_accum_pkg;

  localparam int INSTRET_W = 64;
  localparam int CSR_W = 32;
  localparam int NUM_THREADS_DEF = 4;

  function automatic int cnt_w(input int nt);
    return $clog2(nt + 1);
  endfunction

  function automatic int sum_w(input int nc, input int nt);
    return $clog2(nc * nt + 1);
  endfunction

endpackage

// File: rtl/vx_commit_accum_sum.sv
// Masked adder tree: NUM_CHANNELS counts reduced to one SUM_W total.
// Purely combinational; also used by the perf-counter block.
module vx_commit_accum_sum
  import vx_commit_accum_pkg::*;
#(
  parameter int NUM_CHANNELS = 6,
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int CNT_W = cnt_w(NUM_THREADS),
  parameter int SUM_W = sum_w(NUM_CHANNELS, NUM_THREADS)
) (
  input  logic [NUM_CHANNELS-1:0]       valid,
  input  logic [NUM_CHANNELS*CNT_W-1:0] count,
  output logic [SUM_W-1:0]              sum
);

  localparam int LVL = $clog2(NUM_CHANNELS);
  localparam int P = 1 << LVL;

  // Leaves padded to a power of two; each level halves the width.
  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [SUM_W-1:0] v [P >> l];
    for (genvar j = 0; j < (P >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < NUM_CHANNELS) begin : g_ch
          assign v[j] = valid[j]
            ? SUM_W'(count[j*CNT_W +: CNT_W])
            : '0;
        end else begin : g_pad
          assign v[j] = '0;
        end
      end else begin : g_add
        assign v[j] = g_lvl[l-1].v[2*j]
                    + g_lvl[l-1].v[2*j+1];
      end
    end
  end

  assign sum = g_lvl[LVL].v[0];

endmodule

// File: rtl/vx_commit_accum.sv
// Commit reduction stage plus 64-bit instret counter with
// inhibit and half-word CSR writes (write-then-add).
module vx_commit_accum
  import vx_commit_accum_pkg::*;
#(
  parameter int NUM_CHANNELS = 6,
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int CNT_W = cnt_w(NUM_THREADS),
  parameter int SUM_W = sum_w(NUM_CHANNELS, NUM_THREADS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CHANNELS-1:0]       ch_valid,
  input  logic [NUM_CHANNELS*CNT_W-1:0] ch_count,
  input  logic                          inhibit,
  input  logic                          csr_wr_en,
  input  logic                          csr_wr_hi,
  input  logic [CSR_W-1:0]              csr_wr_data,
  output logic                          commit_valid,
  output logic [SUM_W-1:0]              commit_size,
  output logic [INSTRET_W-1:0]          instret,
  output logic                          busy
);

  logic [SUM_W-1:0]     sum;
  logic [INSTRET_W-1:0] base;
  logic [INSTRET_W-1:0] inc;

  vx_commit_accum_sum #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .NUM_THREADS  (NUM_THREADS),
    .CNT_W        (CNT_W),
    .SUM_W        (SUM_W)
  ) u_sum (
    .valid (ch_valid),
    .count (ch_count),
    .sum   (sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_size  <= '0;
    end else begin
      commit_valid <= (sum != '0);
      commit_size  <= sum;
    end
  end

  always_comb begin
    base = instret;
    if (csr_wr_en) begin
      if (csr_wr_hi) begin
        base = {csr_wr_data, instret[31:0]};
      end else begin
        base = {instret[63:32], csr_wr_data};
      end
    end
  end

  assign inc = (commit_valid && !inhibit)
             ? INSTRET_W'(commit_size)
             : '0;

  // Full-width add so a low-half write still carries upward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else begin
      instret <= base + inc;
    end
  end

  assign busy = commit_valid;

endmodule

// File: tb/tb_vx_commit_accum.sv
// Directed vectors and sequences for vx_commit_accum.
module tb_vx_commit_accum;

  localparam int NC = 6;
  localparam int NT = 4;
  localparam int CW = 3;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   ch_valid;
  logic [NC*CW-1:0] ch_count;
  logic            inhibit;
  logic            csr_wr_en;
  logic            csr_wr_hi;
  logic [31:0]     csr_wr_data;
  logic            commit_valid;
  logic [SW-1:0]   commit_size;
  logic [63:0]     instret;
  logic            busy;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [NC-1:0]    valid;
    logic [NC*CW-1:0] cnt;
    logic [SW-1:0]    exp_size;
    logic             exp_valid;
  } vec_t;

  vec_t tv [7];

  vx_commit_accum #(
    .NUM_CHANNELS (NC),
    .NUM_THREADS  (NT),
    .CNT_W        (CW),
    .SUM_W        (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_valid     (ch_valid),
    .ch_count     (ch_count),
    .inhibit      (inhibit),
    .csr_wr_en    (csr_wr_en),
    .csr_wr_hi    (csr_wr_hi),
    .csr_wr_data  (csr_wr_data),
    .commit_valid (commit_valid),
    .commit_size  (commit_size),
    .instret      (instret),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle_in();
    ch_valid = '0;
    ch_count = '0;
    inhibit = 1'b0;
    csr_wr_en = 1'b0;
    csr_wr_hi = 1'b0;
    csr_wr_data = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    tv[0] = '{6'b111111, 18'o444444, 5'd24, 1'b1};
    tv[1] = '{6'b000000, 18'o444444, 5'd0,  1'b0};
    tv[2] = '{6'b000001, 18'o000001, 5'd1,  1'b1};
    tv[3] = '{6'b111111, 18'o000000, 5'd0,  1'b0};
    tv[4] = '{6'b101010, 18'o443424, 5'd9,  1'b1};
    tv[5] = '{6'b010101, 18'o434241, 5'd6,  1'b1};
    tv[6] = '{6'b100000, 18'o400000, 5'd4,  1'b1};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_instret", instret, 64'd0);
      chk("idle_valid", {63'd0, commit_valid}, 64'd0);
    end

    // Staged 4 is wiped by an async reset.
    ch_valid = 6'b000001;
    ch_count = 18'o000004;
    tick();
    idle_in();
    chk("stage4_size", {59'd0, commit_size}, 64'd4);
    chk("stage4_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_async_size", {59'd0, commit_size}, 64'd0);
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_no_add", instret, 64'd0);

    // Table: stage-1 reduction one edge after presentation.
    for (int i = 0; i < 7; i++) begin
      ch_valid = tv[i].valid;
      ch_count = tv[i].cnt;
      tick();
      chk($sformatf("tv%0d_size", i),
          {59'd0, commit_size}, {59'd0, tv[i].exp_size});
      chk($sformatf("tv%0d_valid", i),
          {63'd0, commit_valid}, {63'd0, tv[i].exp_valid});
    end

    // All channels at 4: size then instret.
    do_reset();
    ch_valid = '1;
    ch_count = 18'o444444;
    tick();
    ch_valid = '0;
    chk("all4_size", {59'd0, commit_size}, 64'd24);
    chk("all4_instret_e1", instret, 64'd0);
    tick();
    chk("all4_instret_e2", instret, 64'd24);
    tick();
    tick();
    chk("invalid_no_change", instret, 64'd24);

    // Streaming 1, 2, 3 with no bubble.
    do_reset();
    ch_valid = 6'b000001;
    ch_count = 18'o000001;
    tick();
    ch_count = 18'o000002;
    tick();
    chk("stream_e2", instret, 64'd1);
    ch_count = 18'o000003;
    tick();
    chk("stream_e3", instret, 64'd3);
    idle_in();
    tick();
    chk("stream_e4", instret, 64'd6);

    // Inhibited commit of 8.
    do_reset();
    inhibit = 1'b1;
    ch_valid = 6'b000011;
    ch_count = 18'o000044;
    tick();
    ch_valid = '0;
    chk("inh_size", {59'd0, commit_size}, 64'd8);
    chk("inh_valid", {63'd0, commit_valid}, 64'd1);
    tick();
    tick();
    chk("inh_instret", instret, 64'd0);
    inhibit = 1'b0;

    // Low write with staged 2 carries into high half.
    do_reset();
    ch_valid = 6'b000001;
    ch_count = 18'o000002;
    tick();
    ch_valid = '0;
    csr_wr_en = 1'b1;
    csr_wr_hi = 1'b0;
    csr_wr_data = 32'hFFFF_FFFF;
    tick();
    csr_wr_en = 1'b0;
    chk("carry_hi", instret, 64'h0000_0001_0000_0001);
    tick();
    chk("carry_hold", instret, 64'h0000_0001_0000_0001);

    // Wrap modulo 2^64.
    do_reset();
    csr_wr_en = 1'b1;
    csr_wr_hi = 1'b1;
    csr_wr_data = 32'hFFFF_FFFF;
    tick();
    chk("wr_hi", instret, 64'hFFFF_FFFF_0000_0000);
    csr_wr_hi = 1'b0;
    ch_valid = 6'b000001;
    ch_count = 18'o000003;
    tick();
    idle_in();
    chk("wr_lo", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap", instret, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
